// File: rtl/matrix_uart_printer.sv
// matrix_uart_printer: reads an m x n matrix from storage and prints it on a
// UART TX line as space-delimited decimal text, one row per line (CR LF).
module matrix_uart_printer #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int BIT_CYCLES = CLK_FREQ / BAUD_RATE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_base_addr,
  input  logic [2:0]  i_dim_m,
  input  logic [2:0]  i_dim_n,
  output logic [7:0]  o_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_uart_tx
);

  localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, READ, WAIT, CONVERT, SEND_DIGIT, SEND_SP, SEND_CR, SEND_LF, FINISH
  } state_t;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  state_t    state;
  tx_state_t tx_state;

  logic [7:0]       base;
  logic [2:0]       dim_m;
  logic [2:0]       dim_n;
  logic [2:0]       row;
  logic [2:0]       col;
  logic [15:0]      conv_sh;
  logic [19:0]      bcd;
  logic [4:0]       conv_cnt;
  logic [2:0]       dig_idx;
  logic [35:0]      dd_next;
  logic             tx_load;
  logic [7:0]       tx_byte;
  logic             tx_ready;
  logic             stop_end;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       tx_sh;
  logic             unused_upper;

  // Only the low 16 bits of a storage word are printed.
  assign unused_upper = ^i_rd_data[31:16];

  // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
  // the {bcd, binary} accumulator left by one.
  function automatic logic [35:0] dabble_step(input logic [35:0] acc);
    logic [35:0] t;
    t = acc;
    for (int i = 0; i < 5; i++) begin
      if (t[16+4*i +: 4] >= 4'd5) t[16+4*i +: 4] = t[16+4*i +: 4] + 4'd3;
    end
    return {t[34:0], 1'b0};
  endfunction

  // Index of the most significant non-zero digit; 0 for a value of zero,
  // so zero still prints a single "0".
  function automatic logic [2:0] top_digit(input logic [19:0] d);
    logic [2:0] k;
    k = 3'd0;
    for (int i = 1; i < 5; i++) begin
      if (d[4*i +: 4] != 4'd0) k = 3'(i);
    end
    return k;
  endfunction

  assign dd_next  = dabble_step({bcd, conv_sh});
  // A byte may be handed over only when the transmitter is idle and the
  // previous strobe has already been consumed.
  assign tx_ready = (tx_state == TX_IDLE) && !tx_load;
  assign stop_end = (tx_state == TX_STOP) && (bit_cnt == BIT_LAST);

  // Main sequencer: fetch element, convert to decimal, emit characters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= 8'd0;
      dim_m     <= 3'd0;
      dim_n     <= 3'd0;
      row       <= 3'd0;
      col       <= 3'd0;
      conv_sh   <= 16'd0;
      bcd       <= 20'd0;
      conv_cnt  <= 5'd0;
      dig_idx   <= 3'd0;
      tx_load   <= 1'b0;
      tx_byte   <= 8'd0;
      o_rd_addr <= 8'd0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      tx_load <= 1'b0;
      o_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            base  <= i_base_addr;
            dim_m <= i_dim_m;
            dim_n <= i_dim_n;
            row   <= 3'd0;
            col   <= 3'd0;
            if (i_dim_m == 3'd0 || i_dim_n == 3'd0) begin
              o_done <= 1'b1;
            end else begin
              o_busy <= 1'b1;
              state  <= READ;
            end
          end
        end
        READ: begin
          o_rd_addr <= base + ({5'd0, row} * {5'd0, dim_n}) + {5'd0, col};
          state     <= WAIT;
        end
        WAIT: begin
          conv_cnt <= 5'd0;
          state    <= CONVERT;
        end
        CONVERT: begin
          if (conv_cnt == 5'd0) begin
            conv_sh  <= i_rd_data[15:0];
            bcd      <= 20'd0;
            conv_cnt <= 5'd1;
          end else begin
            {bcd, conv_sh} <= dd_next;
            conv_cnt       <= conv_cnt + 5'd1;
            if (conv_cnt == 5'd16) begin
              dig_idx <= top_digit(dd_next[35:16]);
              state   <= SEND_DIGIT;
            end
          end
        end
        SEND_DIGIT: begin
          if (tx_ready) begin
            tx_load <= 1'b1;
            tx_byte <= 8'h30 + {4'd0, bcd[{dig_idx, 2'b00} +: 4]};
            if (dig_idx == 3'd0) state <= SEND_SP;
            else dig_idx <= dig_idx - 3'd1;
          end
        end
        SEND_SP: begin
          if (tx_ready) begin
            tx_load <= 1'b1;
            tx_byte <= 8'h20;
            if (col == dim_n - 3'd1) begin
              state <= SEND_CR;
            end else begin
              col   <= col + 3'd1;
              state <= READ;
            end
          end
        end
        SEND_CR: begin
          if (tx_ready) begin
            tx_load <= 1'b1;
            tx_byte <= 8'h0D;
            state   <= SEND_LF;
          end
        end
        SEND_LF: begin
          if (tx_ready) begin
            tx_load <= 1'b1;
            tx_byte <= 8'h0A;
            col     <= 3'd0;
            if (row == dim_m - 3'd1) begin
              state <= FINISH;
            end else begin
              row   <= row + 3'd1;
              state <= READ;
            end
          end
        end
        FINISH: begin
          if (stop_end) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // UART transmitter: start bit, 8 data bits LSB first, stop bit; line
  // comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      tx_sh     <= 8'd0;
      o_uart_tx <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_load) begin
            tx_sh     <= tx_byte;
            bit_cnt   <= '0;
            o_uart_tx <= 1'b0;
            tx_state  <= TX_START;
          end
        end
        TX_START: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt   <= '0;
            bit_idx   <= 3'd0;
            o_uart_tx <= tx_sh[0];
            tx_state  <= TX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_uart_tx <= 1'b1;
              tx_state  <= TX_STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_sh     <= {1'b0, tx_sh[7:1]};
              o_uart_tx <= tx_sh[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            tx_state <= TX_IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

endmodule
